// File: rtl/fpu_scheduler.sv
// fpu_scheduler: round-robin sharing of one FPU between N_REQ requesters, one operation in flight.
// Latency: accept -> rsp_valid after 4 cycles with single-cycle FPU acks; accepts spaced >= 5 cycles.
// Backpressure: result held in RESP until rsp_ready; no grant outside IDLE. FPU_SCHED_TIMEOUT_EN adds a watchdog + fpu_flush.
module fpu_scheduler #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [2*N_REQ-1:0]    req_op,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [1:0]            fpu_sel,
  output logic [31:0]           fpu_a,
  output logic                  fpu_a_stb,
  input  logic                  fpu_a_ack,
  output logic [31:0]           fpu_b,
  output logic                  fpu_b_stb,
  input  logic                  fpu_b_ack,
  input  logic [31:0]           fpu_z,
  input  logic                  fpu_z_stb,
  output logic                  fpu_z_ack
`ifdef FPU_SCHED_TIMEOUT_EN
  ,
  output logic                  fpu_flush
`endif
);

  localparam int          PTR_W   = $clog2(N_REQ);
  localparam logic [1:0]  OP_ILL  = 2'b11;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  if (N_REQ < 2 || N_REQ > 8 || ID_W < $clog2(N_REQ) || TIMEOUT < 1) begin : g_bad_cfg
    $error("fpu_scheduler: unsupported parameter set");
  end

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, RESP} state_t;

  typedef struct packed {
    logic [1:0]      op;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [ID_W-1:0] id;
  } job_t;

  state_t state_q, state_d;
  job_t   job_q;

  logic [N_REQ-1:0][1:0]  op_arr;
  logic [N_REQ-1:0][31:0] a_arr;
  logic [N_REQ-1:0][31:0] b_arr;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W:0]   cand;
  logic             grant_vld;
  logic             accept;
  logic             timeout_hit;
  logic [31:0]      rsp_data_q;
  logic             rsp_err_q;

  assign op_arr = req_op;
  assign a_arr  = req_a;
  assign b_arr  = req_b;

  // First valid requester at or after ptr, wrapping at N_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(N_REQ))
        cand = cand - (PTR_W+1)'(N_REQ);
      if (!grant_vld && req_valid[cand[PTR_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
  end

  assign ptr_nxt = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
  assign accept  = (state_q == IDLE) && grant_vld && !rst;

  always_comb begin
    req_ready = '0;
    if (accept)
      req_ready[grant_idx] = 1'b1;
  end

`ifdef FPU_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] to_cnt_q;
  logic             in_fpu;

  assign in_fpu      = (state_q == SEND_A) || (state_q == SEND_B) || (state_q == WAIT_Z);
  assign timeout_hit = in_fpu && (to_cnt_q == CNT_W'(TIMEOUT));
  assign fpu_flush   = timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      to_cnt_q <= '0;
    else if (accept)
      to_cnt_q <= '0;
    else if (in_fpu && !timeout_hit)
      to_cnt_q <= to_cnt_q + CNT_W'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    fpu_a_stb = 1'b0;
    fpu_b_stb = 1'b0;
    fpu_z_ack = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (accept)
          state_d = (op_arr[grant_idx] == OP_ILL) ? RESP : SEND_A;
      end
      SEND_A: begin
        fpu_a_stb = 1'b1;
        if (fpu_a_ack) state_d = SEND_B;
      end
      SEND_B: begin
        fpu_b_stb = 1'b1;
        if (fpu_b_ack) state_d = WAIT_Z;
      end
      WAIT_Z: begin
        fpu_z_ack = fpu_z_stb && !timeout_hit;
        if (fpu_z_stb) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Watchdog wins over any handshake landing in the same cycle.
    if (timeout_hit)
      state_d = RESP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      job_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ptr_q    <= ptr_nxt;
        job_q.op <= op_arr[grant_idx];
        job_q.a  <= a_arr[grant_idx];
        job_q.b  <= b_arr[grant_idx];
        job_q.id <= ID_W'(grant_idx);
        if (op_arr[grant_idx] == OP_ILL) begin
          rsp_data_q <= QNAN;
          rsp_err_q  <= 1'b1;
        end
      end
      if (state_q == WAIT_Z && fpu_z_stb && !timeout_hit) begin
        rsp_data_q <= fpu_z;
        rsp_err_q  <= 1'b0;
      end
      if (timeout_hit) begin
        rsp_data_q <= QNAN;
        rsp_err_q  <= 1'b1;
      end
    end
  end

  assign fpu_sel  = job_q.op;
  assign fpu_a    = job_q.a;
  assign fpu_b    = job_q.b;
  assign rsp_id   = job_q.id;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_fpu_scheduler.sv
// Scoreboard bench for fpu_scheduler: a stub FPU answers handshakes, expected responses are queued at accept.
`timescale 1ns/1ps
module tb_fpu_scheduler;

  localparam int          N    = 4;
  localparam int          ID_W = 2;
  localparam int          TO   = 20;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N-1:0][1:0]   op_arr;
  logic [N-1:0][31:0]  a_arr;
  logic [N-1:0][31:0]  b_arr;
  logic                rsp_valid, rsp_ready, rsp_err, busy;
  logic [ID_W-1:0]     rsp_id;
  logic [31:0]         rsp_data;
  logic [1:0]          fpu_sel;
  logic [31:0]         fpu_a, fpu_b, fpu_z;
  logic                fpu_a_stb, fpu_a_ack, fpu_b_stb, fpu_b_ack, fpu_z_stb, fpu_z_ack;
`ifdef FPU_SCHED_TIMEOUT_EN
  logic                fpu_flush;
`endif

  fpu_scheduler #(.N_REQ(N), .ID_W(ID_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(op_arr), .req_a(a_arr), .req_b(b_arr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .fpu_sel(fpu_sel),
    .fpu_a(fpu_a), .fpu_a_stb(fpu_a_stb), .fpu_a_ack(fpu_a_ack),
    .fpu_b(fpu_b), .fpu_b_stb(fpu_b_stb), .fpu_b_ack(fpu_b_ack),
    .fpu_z(fpu_z), .fpu_z_stb(fpu_z_stb), .fpu_z_ack(fpu_z_ack)
`ifdef FPU_SCHED_TIMEOUT_EN
    , .fpu_flush(fpu_flush)
`endif
  );

  always #5 clk = ~clk;

  // Stub FPU accepts operands in the cycle they are offered.
  assign fpu_a_ack = fpu_a_stb;
  assign fpu_b_ack = fpu_b_stb;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    logic            err;
  } exp_t;

  exp_t        sb[$];
  int          grants[$];
  int          grant_cyc[$];
  int          n_chk = 0, n_err = 0;
  int          cyc = 0, acc_cyc = 0, flush_cyc = 0;
  int          a_stb_cnt = 0, b_stb_cnt = 0, flush_cnt = 0;
  int          z_delay = 0, zcnt = 0;
  logic        z_en = 1'b1, pending = 1'b0, expect_to = 1'b0;
  logic [31:0] zval = '0;
  logic [N-1:0] sticky = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Stand-in arithmetic: exact for 1.0+2.0, otherwise a cheap operand mix the scheduler must pass through.
  function automatic logic [31:0] fpu_fn(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
    case (sel)
      2'b00:   fpu_fn = (a == 32'h3F80_0000 && b == 32'h4000_0000) ? 32'h4040_0000 : a + b;
      2'b01:   fpu_fn = a * b;
      default: fpu_fn = a ^ {b[15:0], b[31:16]};
    endcase
  endfunction

  // One clock: sample at negedge, then update stub/requesters just after posedge.
  task automatic step();
    logic [N-1:0] acc;
    logic         b_hs, z_hs;
    logic [31:0]  zv;
    exp_t         e;
    @(negedge clk);
    cyc++;
    acc  = req_valid & req_ready;
    b_hs = fpu_b_stb & fpu_b_ack;
    z_hs = fpu_z_stb & fpu_z_ack;
    zv   = fpu_fn(fpu_sel, fpu_a, fpu_b);
    chk("rdy_onehot0", 32'($onehot0(req_ready)), 32'd1);
    if (fpu_a_stb) a_stb_cnt++;
    if (fpu_b_stb) b_stb_cnt++;
`ifdef FPU_SCHED_TIMEOUT_EN
    if (fpu_flush) begin
      flush_cnt++;
      flush_cyc = cyc;
    end
`endif
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        grants.push_back(i);
        grant_cyc.push_back(cyc);
        acc_cyc = cyc;
        e.id   = ID_W'(i);
        e.err  = (op_arr[i] == 2'b11) || expect_to;
        e.data = e.err ? QNAN : fpu_fn(op_arr[i], a_arr[i], b_arr[i]);
        sb.push_back(e);
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("rsp_spurious", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      pending   = 1'b0;
      fpu_z_stb = 1'b0;
    end else begin
      if (z_hs) fpu_z_stb = 1'b0;
      if (b_hs) begin
        pending = 1'b1;
        zcnt    = z_delay;
        zval    = zv;
      end
      if (pending && z_en && !fpu_z_stb) begin
        if (zcnt == 0) begin
          fpu_z_stb = 1'b1;
          fpu_z     = zval;
          pending   = 1'b0;
        end else begin
          zcnt--;
        end
      end
      req_valid = req_valid & ~(acc & ~sticky);
    end
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || busy || req_valid != '0) && n < 200) begin
      step();
      n++;
    end
    chk(tag, 32'(n >= 200), 32'd0);
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 60) begin
      step();
      n++;
    end
    chk(tag, 32'(n >= 60), 32'd0);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({p, "_ctl"}, 32'({busy, rsp_valid, rsp_err, fpu_a_stb, fpu_b_stb, fpu_z_ack}), 32'd0);
    chk({p, "_sel_id"}, 32'({fpu_sel, rsp_id}), 32'd0);
    chk({p, "_rsp_data"}, rsp_data, 32'd0);
    chk({p, "_fpu_a"}, fpu_a, 32'd0);
    chk({p, "_fpu_b"}, fpu_b, 32'd0);
`ifdef FPU_SCHED_TIMEOUT_EN
    chk({p, "_flush"}, 32'(fpu_flush), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = '1;
    op_arr    = '0;
    a_arr     = '0;
    b_arr     = '0;
    rsp_ready = 1'b1;
    fpu_z     = '0;
    fpu_z_stb = 1'b0;
    #12;
    chk_reset("rst");
    req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    step();

    // All four continuously valid from ptr=0: grant order 0,1,2,3,0 at 5-cycle spacing.
    for (int i = 0; i < N; i++) begin
      op_arr[i] = 2'(i % 3);
      a_arr[i]  = 32'h0001_0000 + 32'(i * 17);
      b_arr[i]  = 32'h0000_0300 + 32'(i * 5);
    end
    grants.delete();
    grant_cyc.delete();
    sticky    = '1;
    req_valid = '1;
    n = 0;
    while (grants.size() < 5 && n < 100) begin
      step();
      n++;
    end
    sticky    = '0;
    req_valid = '0;
    chk("rr_count", 32'(grants.size()), 32'd5);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      chk("rr_order", 32'(grants[i]), 32'(i % N));
    for (int i = 1; i < 5 && i < grant_cyc.size(); i++)
      chk("rr_spacing", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd5);
    drain("rr_drain");

    // Single requester 1: 1.0 + 2.0.
    a_stb_cnt = 0;
    b_stb_cnt = 0;
    op_arr[1] = 2'b00;
    a_arr[1]  = 32'h3F80_0000;
    b_arr[1]  = 32'h4000_0000;
    req_valid = 4'b0010;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h2);
    step();
    chk("t1_ready_pulse", 32'(req_ready), 32'h0);
    chk("t1_sel", 32'(fpu_sel), 32'h0);
    chk("t1_fpu_a", fpu_a, 32'h3F80_0000);
    chk("t1_fpu_b", fpu_b, 32'h4000_0000);
    wait_rsp("t1_wait");
    chk("t1_data", rsp_data, 32'h4040_0000);
    chk("t1_id", 32'(rsp_id), 32'd1);
    chk("t1_err", 32'(rsp_err), 32'd0);
    drain("t1_drain");
    chk("t1_a_stb", 32'(a_stb_cnt), 32'd1);
    chk("t1_b_stb", 32'(b_stb_cnt), 32'd1);

    // Illegal op from requester 2: no FPU access.
    a_stb_cnt = 0;
    op_arr[2] = 2'b11;
    a_arr[2]  = 32'h1234_5678;
    req_valid = 4'b0100;
    wait_rsp("ill_wait");
    chk("ill_data", rsp_data, QNAN);
    chk("ill_err", 32'(rsp_err), 32'd1);
    chk("ill_id", 32'(rsp_id), 32'd2);
    drain("ill_drain");
    chk("ill_a_stb", 32'(a_stb_cnt), 32'd0);

    // Response backpressure for 10 cycles with another request pending.
    rsp_ready = 1'b0;
    op_arr[3] = 2'b01;
    a_arr[3]  = 32'd7;
    b_arr[3]  = 32'd9;
    op_arr[0] = 2'b00;
    a_arr[0]  = 32'd100;
    b_arr[0]  = 32'd23;
    req_valid = 4'b1000;
    wait_rsp("bp_wait");
    req_valid = req_valid | 4'b0001;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", rsp_data, 32'd63);
      chk("bp_id", 32'(rsp_id), 32'd3);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_no_grant", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
    drain("bp_drain");

    // Asynchronous reset while waiting on the FPU result.
    z_delay   = 8;
    op_arr[1] = 2'b10;
    a_arr[1]  = 32'hDEAD_BEEF;
    b_arr[1]  = 32'h0BAD_F00D;
    req_valid = 4'b0010;
    n = 0;
    while (!pending && n < 50) begin
      step();
      n++;
    end
    chk("mr_reach_wait", 32'(pending), 32'd1);
    step();
    chk("mr_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_reset("mr");
    sb.delete();
    step();
    step();
    rst     = 1'b0;
    z_delay = 0;
    grants.delete();
    op_arr[0] = 2'b01;
    a_arr[0]  = 32'd3;
    b_arr[0]  = 32'd11;
    op_arr[3] = 2'b00;
    a_arr[3]  = 32'h3F80_0000;
    b_arr[3]  = 32'h4000_0000;
    req_valid = 4'b1001;
    drain("mr_drain");
    chk("mr_grants", 32'(grants.size()), 32'd2);
    if (grants.size() == 2) begin
      chk("mr_first", 32'(grants[0]), 32'd0);
      chk("mr_second", 32'(grants[1]), 32'd3);
    end

`ifdef FPU_SCHED_TIMEOUT_EN
    // FPU never returns a result: watchdog fires 20 cycles after SEND_A entry.
    z_en      = 1'b0;
    expect_to = 1'b1;
    flush_cnt = 0;
    op_arr[2] = 2'b00;
    a_arr[2]  = 32'd1;
    b_arr[2]  = 32'd2;
    req_valid = 4'b0100;
    wait_rsp("to_wait");
    chk("to_err", 32'(rsp_err), 32'd1);
    chk("to_data", rsp_data, QNAN);
    drain("to_drain");
    chk("to_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("to_flush_time", 32'(flush_cyc - (acc_cyc + 1)), 32'd20);
    expect_to = 1'b0;
    z_en      = 1'b1;
    pending   = 1'b0;
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_scheduler.md
Name: fpu_scheduler

Overview:
- Shares one FPU datapath (add/mul/div units with stb/ack operand and result handshakes) between N_REQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Sequences operand A, then operand B, then result capture. Returns the result with the requester's id.
- Sits between client engines and the FPU top; drives its sel and handshake lines.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must be >= clog2(N_REQ).
- TIMEOUT, 1023, watchdog limit in cycles (used only with FPU_SCHED_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request.
- req_ready  out  N_REQ  one-hot grant/accept pulse.
- req_op  in  2*N_REQ  packed op per requester: 00 add, 01 mul, 10 div, 11 illegal.
- req_a  in  32*N_REQ  packed operand A.
- req_b  in  32*N_REQ  packed operand B.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_data  out  32  IEEE-754 single result.
- rsp_err  out  1  illegal op (or timeout when the option is compiled in).
- busy  out  1  high in any state other than IDLE.
- fpu_sel  out  2  op select to the FPU.
- fpu_a  out  32  operand A to the FPU.
- fpu_a_stb  out  1  operand A strobe.
- fpu_a_ack  in  1  operand A accepted.
- fpu_b  out  32  operand B to the FPU.
- fpu_b_stb  out  1  operand B strobe.
- fpu_b_ack  in  1  operand B accepted.
- fpu_z  in  32  FPU result.
- fpu_z_stb  in  1  FPU result valid.
- fpu_z_ack  out  1  result accepted by the scheduler.

Behaviour:
- Reset values: state IDLE, rr pointer 0, all stb/ack outputs 0, rsp_valid 0, rsp_data 0, rsp_id 0, rsp_err 0, busy 0, fpu_sel 0, fpu_a/fpu_b 0. req_ready is forced to 0 while rst is high.
- Reset mid-operation aborts immediately to IDLE. No response is produced; the FPU units share rst.
- FSM states: IDLE, SEND_A, SEND_B, WAIT_Z, RESP.
- IDLE:
  - Grant g is the first i with req_valid[i], searching from ptr upward and wrapping modulo N_REQ.
  - req_ready[g]=1 combinationally in the same cycle. Accept occurs on valid&ready.
  - On accept: latch op, a, b and id=g; set ptr=(g+1) mod N_REQ.
  - Next state is SEND_A; if op==11, go to RESP with rsp_err=1 and rsp_data=32'h7FC00000 and no FPU access.
  - With no req_valid: stay in IDLE, ptr unchanged, req_ready=0.
- SEND_A: fpu_a_stb=1. On fpu_a_ack go to SEND_B.
- SEND_B: fpu_b_stb=1. On fpu_b_ack go to WAIT_Z.
- Operand buses: fpu_a, fpu_b and fpu_sel are held stable from the cycle after accept until WAIT_Z exits.
- WAIT_Z: fpu_z_ack = fpu_z_stb. On fpu_z_stb, register rsp_data=fpu_z and rsp_err=0, then go to RESP.
- RESP: rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable. On rsp_ready go to IDLE; rsp_valid drops the next cycle.
- Back-to-back: no new grant until IDLE. Minimum spacing between accepts is 5 cycles with single-cycle acks.
- req_valid deasserted by a requester while not granted: ignored, no state change.
- Simultaneous requests: exactly one req_ready bit is set per accept; others wait.
- Starvation: any continuously-valid requester is granted within N_REQ accepts.

Optional Feature:
FPU_SCHED_TIMEOUT_EN
- Defined:
  - A counter clears on entry to SEND_A and increments each cycle in SEND_A, SEND_B and WAIT_Z.
  - When it reaches TIMEOUT: go to RESP with rsp_err=1, rsp_data=32'h7FC00000.
  - Also pulse output fpu_flush (1 bit, added port) high for one cycle, for OR-ing into the FPU unit reset.
- Undefined: no counter and no fpu_flush port; the scheduler waits indefinitely.

Test Plan:
- Only req 1 valid, add a=0x3F800000, b=0x40000000 → req_ready=0010 for one cycle, one a_stb/b_stb sequence, fpu_sel=00, rsp_id=1, rsp_data=0x40400000, rsp_err=0.
- All 4 requesters continuously valid, ptr=0 → grant order 0,1,2,3,0; each returns its own result with the correct rsp_id.
- req 2 op=11 → rsp_err=1, rsp_data=0x7FC00000, fpu_a_stb never asserted.
- rsp_ready held low 10 cycles → rsp_valid and outputs stable, no new req_ready, busy=1; release → IDLE next cycle.
- rst asserted during WAIT_Z → outputs at reset values asynchronously; after release, a fresh request completes normally with ptr=0.
- With FPU_SCHED_TIMEOUT_EN and TIMEOUT=20, fpu_z_stb never asserted → rsp_err=1 and a one-cycle fpu_flush pulse exactly 20 cycles after SEND_A entry.
